execute_stage: RTL

- EX stage of the RV64 Zba pipeline. It sits directly downstream of the ID/EX register and consumes all of its E-suffixed outputs.
- It contains the forwarding muxes, the 64-bit ALU with RV64I, W-word and Zba ops, branch/jump resolution, and the EX/MEM pipeline register.
- PCSrcE and PCTargetE are driven combinationally back to fetch. All M-suffixed outputs are registered.

---
 rtl/execute_stage.sv | 179 +++++++++++++++++
 1 files changed

// File: rtl/execute_stage.sv
// EX stage of the RV64 Zba pipeline.
//   - Forwarding muxes for both register operands (ResultW / ALUResultM).
//   - 64-bit ALU: RV64I base ops, W-word forms, Zba shNadd / add.uw / slli.uw.
//   - Branch/jump resolution: PCSrcE and PCTargetE go straight back to fetch.
//   - EX/MEM pipeline register driving every M-suffixed output.
// Ports:
//   clk, rst_n            clock (rising edge), asynchronous active-low reset
//   *E control/data       ID/EX register outputs
//   ForwardAE/ForwardBE   00 reg file, 01 ResultW, 10 ALUResultM, 11 reg file
//   ResultW               writeback value for forwarding
//   FlushM                loads a bubble into EX/MEM at the next edge
//   PCSrcE, PCTargetE     combinational redirect to fetch
//   *M outputs            registered EX/MEM contents
module execute_stage #(
  parameter int unsigned XLEN = 64
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            RegWriteE,
  input  logic            MemWriteE,
  input  logic            JumpE,
  input  logic            BranchE,
  input  logic            ALUSrcE,
  input  logic [1:0]      ResultSrcE,
  input  logic [3:0]      ALUControlE,
  input  logic [6:0]      OPE,
  input  logic [2:0]      funct3E,
  input  logic [XLEN-1:0] PCE,
  input  logic [XLEN-1:0] ExtImmE,
  input  logic [XLEN-1:0] PCPlus4E,
  input  logic [XLEN-1:0] RD1E,
  input  logic [XLEN-1:0] RD2E,
  input  logic [4:0]      RdE,
  input  logic [1:0]      ForwardAE,
  input  logic [1:0]      ForwardBE,
  input  logic [XLEN-1:0] ResultW,
  input  logic            FlushM,
  output logic            PCSrcE,
  output logic [XLEN-1:0] PCTargetE,
  output logic            RegWriteM,
  output logic            MemWriteM,
  output logic [1:0]      ResultSrcM,
  output logic [2:0]      funct3M,
  output logic [4:0]      RdM,
  output logic [XLEN-1:0] ALUResultM,
  output logic [XLEN-1:0] WriteDataM,
  output logic [XLEN-1:0] PCPlus4M
);

  localparam logic [6:0] OpLui    = 7'b0110111;
  localparam logic [6:0] OpAuipc  = 7'b0010111;
  localparam logic [6:0] OpJalr   = 7'b1100111;
  localparam logic [6:0] OpOp32   = 7'b0111011;
  localparam logic [6:0] OpOpImm32 = 7'b0011011;

  function automatic logic [63:0] sext32(input logic [31:0] w);
    return {{32{w[31]}}, w};
  endfunction

  // Operand selection
  logic [63:0] src_a_fwd, src_b_reg, src_a, src_b;

  always_comb begin
    unique case (ForwardAE)
      2'b01:   src_a_fwd = ResultW;
      2'b10:   src_a_fwd = ALUResultM;
      default: src_a_fwd = RD1E;
    endcase
    unique case (ForwardBE)
      2'b01:   src_b_reg = ResultW;
      2'b10:   src_b_reg = ALUResultM;
      default: src_b_reg = RD2E;
    endcase
  end

  assign src_a = (OPE == OpLui) ? 64'd0 : (OPE == OpAuipc) ? PCE : src_a_fwd;
  assign src_b = ALUSrcE ? ExtImmE : src_b_reg;

  // ALU
  logic        is_word, is_op32;
  logic [5:0]  shamt6;
  logic [4:0]  shamt5;
  logic [63:0] zext_a, sh_base, sra64, alu_result;
  logic [31:0] addw, subw, sllw, srlw, sraw;

  assign is_op32 = (OPE == OpOp32);
  assign is_word = is_op32 || (OPE == OpOpImm32);
  assign shamt6  = src_b[5:0];
  assign shamt5  = src_b[4:0];
  assign zext_a  = {32'd0, src_a[31:0]};
  // shNadd under OP-32 are the .uw variants
  assign sh_base = is_op32 ? zext_a : src_a;
  assign sra64   = $signed(src_a) >>> shamt6;
  assign addw    = src_a[31:0] + src_b[31:0];
  assign subw    = src_a[31:0] - src_b[31:0];
  assign sllw    = src_a[31:0] << shamt5;
  assign srlw    = src_a[31:0] >> shamt5;
  assign sraw    = $signed(src_a[31:0]) >>> shamt5;

  always_comb begin
    alu_result = src_b;
    unique case (ALUControlE)
      4'b0000: alu_result = is_word ? sext32(addw) : src_a + src_b;
      4'b0001: alu_result = is_word ? sext32(subw) : src_a - src_b;
      4'b0010: alu_result = src_a & src_b;
      4'b0011: alu_result = src_a | src_b;
      4'b0100: alu_result = src_a ^ src_b;
      4'b0101: alu_result = {63'd0, $signed(src_a) < $signed(src_b)};
      4'b0110: alu_result = {63'd0, src_a < src_b};
      4'b0111: alu_result = is_word ? sext32(sllw) : src_a << shamt6;
      4'b1000: alu_result = is_word ? sext32(srlw) : src_a >> shamt6;
      4'b1001: alu_result = is_word ? sext32(sraw) : sra64;
      4'b1010: alu_result = (sh_base << 1) + src_b;
      4'b1011: alu_result = (sh_base << 2) + src_b;
      4'b1100: alu_result = (sh_base << 3) + src_b;
      4'b1101: alu_result = zext_a + src_b;
      4'b1110: alu_result = zext_a << shamt6;
      default: alu_result = src_b;
    endcase
  end

  // Branch resolution compares the forwarded registers, never the immediate
  logic        br_eq, br_lt, br_ltu, br_taken;
  logic [63:0] jalr_sum;

  assign br_eq  = (src_a_fwd == src_b_reg);
  assign br_lt  = ($signed(src_a_fwd) < $signed(src_b_reg));
  assign br_ltu = (src_a_fwd < src_b_reg);

  always_comb begin
    br_taken = 1'b0;
    unique case (funct3E)
      3'b000:  br_taken = br_eq;
      3'b001:  br_taken = !br_eq;
      3'b100:  br_taken = br_lt;
      3'b101:  br_taken = !br_lt;
      3'b110:  br_taken = br_ltu;
      3'b111:  br_taken = !br_ltu;
      default: br_taken = 1'b0;
    endcase
  end

  assign jalr_sum  = src_a_fwd + ExtImmE;
  assign PCSrcE    = JumpE | (BranchE & br_taken);
  assign PCTargetE = (OPE == OpJalr) ? {jalr_sum[63:1], 1'b0} : PCE + ExtImmE;

  // EX/MEM register; flush wins over capture
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      RegWriteM  <= 1'b0;
      MemWriteM  <= 1'b0;
      ResultSrcM <= 2'd0;
      funct3M    <= 3'd0;
      RdM        <= 5'd0;
      ALUResultM <= '0;
      WriteDataM <= '0;
      PCPlus4M   <= '0;
    end else if (FlushM) begin
      RegWriteM  <= 1'b0;
      MemWriteM  <= 1'b0;
      ResultSrcM <= 2'd0;
      funct3M    <= 3'd0;
      RdM        <= 5'd0;
      ALUResultM <= '0;
      WriteDataM <= '0;
      PCPlus4M   <= '0;
    end else begin
      RegWriteM  <= RegWriteE;
      MemWriteM  <= MemWriteE;
      ResultSrcM <= ResultSrcE;
      funct3M    <= funct3E;
      RdM        <= RdE;
      ALUResultM <= alu_result;
      WriteDataM <= src_b_reg;
      PCPlus4M   <= PCPlus4E;
    end
  end

endmodule
